// File: rtl/ram_arb_pkg.sv
// Shared definitions for the two-port RAM arbiter: FSM state encoding and port indices.
package ram_arb_pkg;

    typedef enum logic {
        ARB_IDLE   = 1'b0,
        ARB_ACCESS = 1'b1
    } arb_state_e;

    localparam logic ARB_PORT_CPU    = 1'b0;
    localparam logic ARB_PORT_LOADER = 1'b1;

endpackage

// File: rtl/rr_pick2.sv
// Combinational 2-way picker with lock-owner filtering.
// Build option RAM_ARBITER_FIXED_PRIO_EN: port 0 wins every tie and last_i is ignored.
module rr_pick2
    import ram_arb_pkg::*;
(
    input  logic [1:0] req_i,
    input  logic       last_i,
    input  logic       owner_i,
    input  logic       owner_valid_i,
    output logic       idx_o,
    output logic       valid_o
);

    logic [1:0] eff_req;

`ifdef RAM_ARBITER_FIXED_PRIO_EN
    logic unused_last;
    assign unused_last = last_i;
`endif

    always_comb begin
        eff_req = req_i;
        if (owner_valid_i) begin
            eff_req = owner_i ? (req_i & 2'b10) : (req_i & 2'b01);
        end
        valid_o = |eff_req;
        idx_o   = eff_req[1];
        if (&eff_req) begin
`ifdef RAM_ARBITER_FIXED_PRIO_EN
            idx_o = ARB_PORT_CPU;
`else
            idx_o = ~last_i;
`endif
        end
    end

endmodule

// File: rtl/ram_arbiter.sv
// Shares one combinational-read RAM between the cpu (port 0) and the loader (port 1), one access per grant.
// Build option RAM_ARBITER_FIXED_PRIO_EN switches tie-breaking from round-robin to fixed port-0 priority.
module ram_arbiter
    import ram_arb_pkg::*;
#(
    parameter int ADDRESS_WIDTH = 10,
    parameter int WIDTH         = 32
) (
    input  logic                     clk,
    input  logic                     rstn,
    input  logic                     req0,
    input  logic                     req1,
    input  logic                     lock0,
    input  logic                     lock1,
    input  logic                     we0,
    input  logic                     we1,
    input  logic [ADDRESS_WIDTH-1:0] addr0,
    input  logic [ADDRESS_WIDTH-1:0] addr1,
    input  logic [WIDTH-1:0]         wdata0,
    input  logic [WIDTH-1:0]         wdata1,
    output logic                     gnt0,
    output logic                     gnt1,
    output logic                     done0,
    output logic                     done1,
    output logic [WIDTH-1:0]         rdata,
    output logic [ADDRESS_WIDTH-1:0] ram_rd_addr,
    output logic [ADDRESS_WIDTH-1:0] ram_wr_addr,
    output logic [WIDTH-1:0]         ram_data_in,
    output logic                     ram_wr_enable,
    input  logic [WIDTH-1:0]         ram_data_out
);

    arb_state_e               state_q, state_d;
    logic                     last_q, last_d;
    logic                     port_q, port_d;
    logic                     owner_q, owner_d;
    logic                     owner_valid_q, owner_valid_d;
    logic [1:0]               gnt_q, gnt_d;
    logic [1:0]               done_q, done_d;
    logic [WIDTH-1:0]         rdata_q, rdata_d;
    logic [WIDTH-1:0]         data_in_q, data_in_d;
    logic [ADDRESS_WIDTH-1:0] rd_addr_q, rd_addr_d;
    logic [ADDRESS_WIDTH-1:0] wr_addr_q, wr_addr_d;
    logic                     wr_en_q, wr_en_d;

    logic [1:0] req_v, lock_v;
    logic       owner_hold;
    logic       pick_idx, pick_valid;

    assign req_v  = {req1, req0};
    assign lock_v = {lock1, lock0};
    // Ownership lapses as soon as the owner neither requests nor holds its lock.
    assign owner_hold = owner_valid_q & (req_v[owner_q] | lock_v[owner_q]);

    rr_pick2 u_pick (
        .req_i         (req_v),
        .last_i        (last_q),
        .owner_i       (owner_q),
        .owner_valid_i (owner_hold),
        .idx_o         (pick_idx),
        .valid_o       (pick_valid)
    );

    always_comb begin
        state_d       = state_q;
        last_d        = last_q;
        port_d        = port_q;
        owner_d       = owner_q;
        owner_valid_d = owner_valid_q;
        gnt_d         = 2'b00;
        done_d        = 2'b00;
        rdata_d       = rdata_q;
        data_in_d     = data_in_q;
        rd_addr_d     = rd_addr_q;
        wr_addr_d     = wr_addr_q;
        wr_en_d       = 1'b0;
        case (state_q)
            ARB_IDLE: begin
                owner_valid_d = owner_hold;
                if (pick_valid) begin
                    state_d       = ARB_ACCESS;
                    last_d        = pick_idx;
                    port_d        = pick_idx;
                    owner_d       = pick_idx;
                    owner_valid_d = lock_v[pick_idx];
                    if (pick_idx == ARB_PORT_CPU) begin
                        gnt_d     = 2'b01;
                        rd_addr_d = addr0;
                        wr_addr_d = addr0;
                        data_in_d = wdata0;
                        wr_en_d   = we0;
                    end else begin
                        gnt_d     = 2'b10;
                        rd_addr_d = addr1;
                        wr_addr_d = addr1;
                        data_in_d = wdata1;
                        wr_en_d   = we1;
                    end
                end
            end
            ARB_ACCESS: begin
                state_d = ARB_IDLE;
                done_d  = (port_q == ARB_PORT_CPU) ? 2'b01 : 2'b10;
                if (!wr_en_q) begin
                    rdata_d = ram_data_out;
                end
            end
            default: state_d = ARB_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q       <= ARB_IDLE;
            last_q        <= ARB_PORT_LOADER;
            port_q        <= ARB_PORT_CPU;
            owner_q       <= ARB_PORT_CPU;
            owner_valid_q <= 1'b0;
            gnt_q         <= 2'b00;
            done_q        <= 2'b00;
            rdata_q       <= '0;
            data_in_q     <= '0;
            rd_addr_q     <= '0;
            wr_addr_q     <= '0;
            wr_en_q       <= 1'b0;
        end else begin
            state_q       <= state_d;
            last_q        <= last_d;
            port_q        <= port_d;
            owner_q       <= owner_d;
            owner_valid_q <= owner_valid_d;
            gnt_q         <= gnt_d;
            done_q        <= done_d;
            rdata_q       <= rdata_d;
            data_in_q     <= data_in_d;
            rd_addr_q     <= rd_addr_d;
            wr_addr_q     <= wr_addr_d;
            wr_en_q       <= wr_en_d;
        end
    end

    assign gnt0          = gnt_q[0];
    assign gnt1          = gnt_q[1];
    assign done0         = done_q[0];
    assign done1         = done_q[1];
    assign rdata         = rdata_q;
    assign ram_rd_addr   = rd_addr_q;
    assign ram_wr_addr   = wr_addr_q;
    assign ram_data_in   = data_in_q;
    assign ram_wr_enable = wr_en_q;

endmodule

// File: tb/tb_ram_arbiter.sv
// Self-checking bench for ram_arbiter: directed scenarios plus randomized requesters against an access-level model.
module tb_ram_arbiter;

    localparam int AW = 10;
    localparam int DW = 32;
`ifdef RAM_ARBITER_FIXED_PRIO_EN
    localparam bit FIXED = 1'b1;
`else
    localparam bit FIXED = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rstn = 1'b0;
    logic          req0 = 1'b0, req1 = 1'b0, lock0 = 1'b0, lock1 = 1'b0, we0 = 1'b0, we1 = 1'b0;
    logic [AW-1:0] addr0 = '0, addr1 = '0;
    logic [DW-1:0] wdata0 = '0, wdata1 = '0;
    logic          gnt0, gnt1, done0, done1, ram_wr_enable;
    logic [DW-1:0] rdata, ram_data_in, ram_data_out;
    logic [AW-1:0] ram_rd_addr, ram_wr_addr;

    always #5 clk = ~clk;

    ram_arbiter #(.ADDRESS_WIDTH(AW), .WIDTH(DW)) dut (
        .clk(clk), .rstn(rstn),
        .req0(req0), .req1(req1), .lock0(lock0), .lock1(lock1),
        .we0(we0), .we1(we1), .addr0(addr0), .addr1(addr1),
        .wdata0(wdata0), .wdata1(wdata1),
        .gnt0(gnt0), .gnt1(gnt1), .done0(done0), .done1(done1), .rdata(rdata),
        .ram_rd_addr(ram_rd_addr), .ram_wr_addr(ram_wr_addr), .ram_data_in(ram_data_in),
        .ram_wr_enable(ram_wr_enable), .ram_data_out(ram_data_out)
    );

    function automatic logic [31:0] init_word(input int i);
        return (32'(i) * 32'h9E3779B1) ^ 32'hA5A50000;
    endfunction

    // The RAM the arbiter drives: combinational read, write on the clock edge.
    logic [DW-1:0] mem [0:1023];
    assign ram_data_out = mem[ram_rd_addr];
    initial begin
        for (int i = 0; i < 1024; i++) mem[i] = init_word(i);
        mem[10'h03C] = 32'h00400137;
        forever begin
            @(posedge clk);
            if (ram_wr_enable) mem[ram_wr_addr] <= ram_data_in;
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Access-level reference model
    logic [DW-1:0] ref_mem [0:1023];
    bit            m_busy, m_last, m_own_v, m_own, m_port, m_we;
    logic [AW-1:0] m_addr;
    logic [DW-1:0] m_wdata;
    logic [1:0]    e_gnt, e_done;
    logic          e_wen;
    logic [DW-1:0] e_rdata;

    int tests = 0;
    int fails = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_busy  = 1'b0;
        m_last  = 1'b1;
        m_own_v = 1'b0;
        m_own   = 1'b0;
        e_gnt   = 2'b00;
        e_done  = 2'b00;
        e_wen   = 1'b0;
        e_rdata = '0;
    endtask

    // Predicts what the outputs show after the coming clock edge, given the inputs now applied.
    task automatic model_edge();
        logic [1:0] rq, lk;
        bit w, found;
        rq = {req1, req0};
        lk = {lock1, lock0};
        e_gnt  = 2'b00;
        e_done = 2'b00;
        e_wen  = 1'b0;
        w      = 1'b0;
        if (!rstn) begin
            model_reset();
        end else if (m_busy) begin
            e_done[m_port] = 1'b1;
            if (m_we) ref_mem[m_addr] = m_wdata;
            else e_rdata = ref_mem[m_addr];
            m_busy = 1'b0;
        end else begin
            if (m_own_v && !rq[m_own] && !lk[m_own]) m_own_v = 1'b0;
            found = 1'b1;
            if (m_own_v) begin
                w = m_own;
                found = rq[m_own];
            end else if (rq == 2'b11) w = FIXED ? 1'b0 : !m_last;
            else if (rq == 2'b01) w = 1'b0;
            else if (rq == 2'b10) w = 1'b1;
            else found = 1'b0;
            if (found) begin
                m_busy  = 1'b1;
                m_port  = w;
                m_we    = w ? we1 : we0;
                m_addr  = w ? addr1 : addr0;
                m_wdata = w ? wdata1 : wdata0;
                m_last  = w;
                m_own   = w;
                m_own_v = lk[w];
                e_gnt[w] = 1'b1;
                e_wen    = m_we;
            end
        end
    endtask

    // One clock: predict, advance, compare, return at the following negedge.
    task automatic cycle();
        model_edge();
        @(posedge clk);
        #1;
        chk("gnt0", 32'(gnt0), 32'(e_gnt[0]));
        chk("gnt1", 32'(gnt1), 32'(e_gnt[1]));
        chk("done0", 32'(done0), 32'(e_done[0]));
        chk("done1", 32'(done1), 32'(e_done[1]));
        chk("wr_enable", 32'(ram_wr_enable), 32'(e_wen));
        chk("rdata", rdata, e_rdata);
        chk("gnt_exclusive", 32'(gnt0 & gnt1), 32'd0);
        if (e_wen) begin
            chk("wr_addr", 32'(ram_wr_addr), 32'(m_addr));
            chk("wr_data", ram_data_in, m_wdata);
        end
        if (!rstn) chk("reset_ram_side", 32'(ram_rd_addr) | 32'(ram_wr_addr) | ram_data_in, 32'd0);
        @(negedge clk);
    endtask

    task automatic xfer(input bit p, input bit we, input logic [AW-1:0] a, input logic [DW-1:0] d,
                        output int gnt_lat, output int done_lat, output logic [DW-1:0] rd, output int wen_cnt);
        if (!p) begin req0 = 1'b1; we0 = we; addr0 = a; wdata0 = d; lock0 = 1'b0; end
        else    begin req1 = 1'b1; we1 = we; addr1 = a; wdata1 = d; lock1 = 1'b0; end
        gnt_lat = -1; done_lat = -1; wen_cnt = 0; rd = '0;
        for (int i = 1; i <= 20 && done_lat < 0; i++) begin
            cycle();
            if (ram_wr_enable) wen_cnt++;
            if ((p ? gnt1 : gnt0) && gnt_lat < 0) begin
                gnt_lat = i;
                if (!p) req0 = 1'b0; else req1 = 1'b0;
            end
            if (p ? done1 : done0) begin
                done_lat = i;
                rd = rdata;
            end
        end
        chk("xfer_completed", 32'(done_lat > 0), 32'd1);
    endtask

    task automatic do_reset();
        rstn = 1'b0;
        cycle();
        cycle();
        rstn = 1'b1;
    endtask

    task automatic raise(input bit p);
        logic w, l;
        logic [AW-1:0] a;
        logic [DW-1:0] d;
        w = 1'($urandom_range(0, 1));
        a = AW'($urandom_range(0, 15));
        d = $urandom;
        l = ($urandom_range(0, 3) == 0);
        if (!p) begin req0 = 1'b1; we0 = w; addr0 = a; wdata0 = d; lock0 = l; end
        else    begin req1 = 1'b1; we1 = w; addr1 = a; wdata1 = d; lock1 = l; end
    endtask

    int            gl, dl, wc, n0, k;
    logic [DW-1:0] rd;
    int            order[$];

    initial begin
        for (int i = 0; i < 1024; i++) ref_mem[i] = init_word(i);
        ref_mem[10'h03C] = 32'h00400137;
        model_reset();
        @(negedge clk);
        do_reset();
        cycle();

        // single read, latency 1 to grant and 2 to done
        xfer(1'b0, 1'b0, 10'h03C, '0, gl, dl, rd, wc);
        chk("read_gnt_latency", 32'(gl), 32'd1);
        chk("read_done_latency", 32'(dl), 32'd2);
        chk("read_rdata", rd, 32'h00400137);

        // loader write then read back
        xfer(1'b1, 1'b1, 10'h008, 32'hDEADBEEF, gl, dl, rd, wc);
        chk("write_wen_cycles", 32'(wc), 32'd1);
        xfer(1'b1, 1'b0, 10'h008, '0, gl, dl, rd, wc);
        chk("readback_rdata", rd, 32'hDEADBEEF);
        chk("read_wen_cycles", 32'(wc), 32'd0);

        // reset in the middle of a write access
        req0 = 1'b1; we0 = 1'b1; addr0 = 10'h03C; wdata0 = 32'h11111111; lock0 = 1'b0;
        cycle();
        chk("midwrite_wen_before_reset", 32'(ram_wr_enable), 32'd1);
        rstn = 1'b0;
        #1;
        chk("midwrite_wen_cleared", 32'(ram_wr_enable), 32'd0);
        chk("midwrite_gnt_cleared", 32'(gnt0), 32'd0);
        model_reset();
        req0 = 1'b0; we0 = 1'b0;
        cycle();
        cycle();
        rstn = 1'b1;
        cycle();
        xfer(1'b0, 1'b0, 10'h03C, '0, gl, dl, rd, wc);
        chk("midwrite_mem_unchanged", rd, 32'h00400137);

        // tie from reset: round-robin alternates (fixed priority: port 0 every time)
        do_reset();
        req0 = 1'b1; req1 = 1'b1; addr0 = 10'h001; addr1 = 10'h002;
        order.delete();
        for (int i = 0; i < 8; i++) begin
            cycle();
            if (gnt0) order.push_back(0);
            if (gnt1) order.push_back(1);
        end
        req0 = 1'b0; req1 = 1'b0;
        chk("tie_grant_count", 32'(order.size()), 32'd4);
        for (int i = 0; i < order.size() && i < 4; i++)
            chk("tie_grant_order", 32'(order[i]), FIXED ? 32'd0 : 32'(i % 2));
        cycle();
        cycle();

        // lock: three locked port-0 accesses starve port 1, which then gets in
        do_reset();
        req1 = 1'b1; we1 = 1'b0; addr1 = 10'h005;
        req0 = 1'b1; we0 = 1'b0; addr0 = 10'h006; lock0 = 1'b1;
        order.delete();
        n0 = 0;
        for (int i = 0; i < 30 && order.size() < 4; i++) begin
            cycle();
            if (gnt1) begin order.push_back(1); req1 = 1'b0; end
            if (gnt0) begin
                order.push_back(0);
                n0++;
                if (n0 == 3) begin req0 = 1'b0; lock0 = 1'b0; end
            end
        end
        chk("lock_grant_count", 32'(order.size()), 32'd4);
        for (int i = 0; i < order.size() && i < 4; i++)
            chk("lock_grant_order", 32'(order[i]), (i < 3) ? 32'd0 : 32'd1);
        req0 = 1'b0; req1 = 1'b0; lock0 = 1'b0;
        cycle();
        cycle();

`ifdef RAM_ARBITER_FIXED_PRIO_EN
        // fixed priority: six accesses all to port 0, then port 1 once port 0 lets go
        do_reset();
        req0 = 1'b1; req1 = 1'b1; we0 = 1'b0; we1 = 1'b0;
        n0 = 0;
        k = -1;
        for (int i = 0; i < 40 && k < 0; i++) begin
            cycle();
            if (gnt0) begin
                n0++;
                if (n0 == 6) req0 = 1'b0;
            end
            if (gnt1) begin k = n0; req1 = 1'b0; end
        end
        chk("fixed_port1_after_six_port0", 32'(k), 32'd6);
        cycle();
        cycle();
`endif

        // randomized requesters
        for (int n = 0; n < 800; n++) begin
            cycle();
            if (req0 && gnt0) begin
                req0 = 1'b0; lock0 = 1'b0;
                if ($urandom_range(0, 1) == 1) raise(1'b0);
            end else if (!req0 && $urandom_range(0, 3) == 0) raise(1'b0);
            if (req1 && gnt1) begin
                req1 = 1'b0; lock1 = 1'b0;
                if ($urandom_range(0, 1) == 1) raise(1'b1);
            end else if (!req1 && $urandom_range(0, 3) == 0) raise(1'b1);
        end
        req0 = 1'b0; req1 = 1'b0; lock0 = 1'b0; lock1 = 1'b0;
        for (int n = 0; n < 4; n++) cycle();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
